hazard_ctrl: RTL and testbench

- Stall and forwarding controller for the 5-stage MIPS pipeline.
- Sits directly downstream of the decoder. It consumes the D-stage Tuse_rs/Tuse_rt/Tnew and destination info produced at decode.
- Keeps a scoreboard of in-flight producers in E, M and W.
- Drives the pipeline stall/bubble and the forwarding mux selects for D-, E- and M-stage operand reads.

---
 rtl/hazard_ctrl_pkg.sv | 51 +++++
 rtl/hazard_match.sv | 25 ++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared types and helpers for the pipeline hazard controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  localparam int SB_AW = 5;  // register address width held in the scoreboard
  localparam int SB_TW = 4;  // Tuse/Tnew width held in the scoreboard

  // Scoreboard stage indices
  localparam int ST_E = 0;
  localparam int ST_M = 1;
  localparam int ST_W = 2;

  // Forwarding mux selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;

  // Tuse value meaning "operand never read"
  localparam logic [SB_TW-1:0] T_MAX = 4'd15;
  localparam logic [SB_TW-1:0] T_ONE = 4'd1;

  typedef struct packed {
    logic             vld;   // present, writes regfile, a3 != 0
    logic [SB_AW-1:0] a3;
    logic [SB_TW-1:0] tnew;  // cycles until the result exists, stage-relative
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
  } sb_entry_t;

  // Saturating decrement: a ready result stays ready.
  function automatic logic [SB_TW-1:0] dec_sat(input logic [SB_TW-1:0] t);
    return (t == '0) ? '0 : t - T_ONE;
  endfunction

  // Entry as seen one stage further down the pipe.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r      = e;
    r.tnew = dec_sat(e.tnew);
    return r;
  endfunction

  // Nearest producer wins: a ready M result beats any W result.
  function automatic logic [1:0] fwd_sel(input logic m_ready, input logic w_hit);
    if (m_ready)    return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Purpose: compare one source register against one scoreboard entry.
// Latency: combinational.
// Backpressure: none; pure compare.
// Ports: src (register read), entry (scoreboard slot) -> hit (entry will write
//        src), hit_ready (hit and the value already exists, tnew == 0).
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [SB_AW-1:0] src,
  input  sb_entry_t        entry,
  output logic             hit,
  output logic             hit_ready
);

  // $0 is hardwired: it can never be a dependency.
  always_comb begin
    hit       = entry.vld && (src != '0) && (entry.a3 == src);
    hit_ready = hit && (entry.tnew == '0);
  end

  // The source fields of the entry are only meaningful to the entry's own consumer.
  logic unused_fields;
  assign unused_fields = ^{entry.rs, entry.rt};

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall and forwarding control for the 5-stage MIPS pipeline.
// Latency: stall/forward selects combinational from D inputs + E/M/W scoreboard.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; D inputs held upstream.
// Ports: D-stage decode info (d_*) in; stall, fwd_d_rs/rt, fwd_e_rs/rt, fwd_m_rt out.
// Macro HAZARD_STATS_EN adds stall_cnt, a wrapping count of stalled cycles.
// REG_AW/TW must match SB_AW/SB_TW in hazard_ctrl_pkg.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = SB_AW,
  parameter int TW     = SB_TW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [TW-1:0]     d_tnew,
  input  logic [REG_AW-1:0] d_a3,
  input  logic              d_regwrite,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt
);

  sb_entry_t sb [3];
  sb_entry_t d_entry;

  // Tnew from the decoder is D-relative; E holds it one cycle later.
  always_comb begin
    d_entry      = '0;
    d_entry.vld  = d_valid && d_regwrite && (d_a3 != '0);
    d_entry.a3   = d_a3;
    d_entry.tnew = dec_sat(d_tnew);
    d_entry.rs   = d_rs;
    d_entry.rt   = d_rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb[ST_E] <= '0;
      sb[ST_M] <= '0;
      sb[ST_W] <= '0;
    end else begin
      sb[ST_E] <= stall ? '0 : d_entry;
      sb[ST_M] <= sb_age(sb[ST_E]);
      sb[ST_W] <= sb_age(sb[ST_M]);
    end
  end

  // D sources against every stage: E/M for stalls, M/W for forwarding.
  logic [ST_W:ST_E] hit_drs, rdy_drs, hit_drt, rdy_drt;
  for (genvar s = ST_E; s <= ST_W; s++) begin : g_d
    hazard_match u_rs (.src(d_rs), .entry(sb[s]), .hit(hit_drs[s]), .hit_ready(rdy_drs[s]));
    hazard_match u_rt (.src(d_rt), .entry(sb[s]), .hit(hit_drt[s]), .hit_ready(rdy_drt[s]));
  end

  // E-stage operands against the two producers ahead of it.
  logic [ST_W:ST_M] hit_ers, rdy_ers, hit_ert, rdy_ert;
  for (genvar s = ST_M; s <= ST_W; s++) begin : g_e
    hazard_match u_rs (.src(sb[ST_E].rs), .entry(sb[s]), .hit(hit_ers[s]), .hit_ready(rdy_ers[s]));
    hazard_match u_rt (.src(sb[ST_E].rt), .entry(sb[s]), .hit(hit_ert[s]), .hit_ready(rdy_ert[s]));
  end

  // Store data in M can only come from W.
  logic hit_mrt, rdy_mrt;
  hazard_match u_m_rt (.src(sb[ST_M].rt), .entry(sb[ST_W]), .hit(hit_mrt), .hit_ready(rdy_mrt));

  logic stall_rs, stall_rt;

  // A producer in W has tnew 0, so only E and M can force a stall.
  always_comb begin
    stall_rs = (d_tuse_rs != T_MAX) &&
               ((hit_drs[ST_E] && (sb[ST_E].tnew > d_tuse_rs)) ||
                (hit_drs[ST_M] && (sb[ST_M].tnew > d_tuse_rs)));
    stall_rt = (d_tuse_rt != T_MAX) &&
               ((hit_drt[ST_E] && (sb[ST_E].tnew > d_tuse_rt)) ||
                (hit_drt[ST_M] && (sb[ST_M].tnew > d_tuse_rt)));
    stall    = d_valid && (stall_rs || stall_rt);

    // Selects are produced even while stalled; consumers ignore them then.
    fwd_d_rs = fwd_sel(rdy_drs[ST_M], hit_drs[ST_W]);
    fwd_d_rt = fwd_sel(rdy_drt[ST_M], hit_drt[ST_W]);
    fwd_e_rs = fwd_sel(rdy_ers[ST_M], hit_ers[ST_W]);
    fwd_e_rt = fwd_sel(rdy_ert[ST_M], hit_ert[ST_W]);
    fwd_m_rt = hit_mrt ? FWD_W : FWD_NONE;
  end

  // Readiness is irrelevant for E (stall path) and W (always ready).
  logic unused_rdy;
  assign unused_rdy = ^{rdy_drs[ST_E], rdy_drs[ST_W], rdy_drt[ST_E], rdy_drt[ST_W],
                        rdy_ers[ST_W], rdy_ert[ST_W], rdy_mrt};

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl against an age-based pipeline model.
// Latency: compares combinational outputs once per cycle at the falling edge.
// Backpressure: D inputs are held while the model predicts a stall.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [3:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic       d_regwrite = 1'b0;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew), .d_a3(d_a3),
    .d_regwrite(d_regwrite),
`ifdef HAZARD_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: instructions by distance from D (1=E, 2=M, 3=W), keeping the
  // decoder's D-relative tnew; the tnew at distance k is max(0, tnew-k).
  typedef struct {
    bit v;
    bit rw;
    int a3;
    int rs;
    int rt;
    int tnew;
  } ins_t;

  ins_t        pipe [1:3];
  int unsigned m_cnt;
  bit          e_stall;
  int          e_fd_rs, e_fd_rt, e_fe_rs, e_fe_rt, e_fm_rt;
  logic        obs_stall;
  logic [1:0]  obs_fd_rs, obs_fd_rt, obs_fe_rs, obs_fm_rt;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic void model_reset();
    for (int k = 1; k <= 3; k++) pipe[k] = bubble();
    m_cnt = 0;
  endfunction

  function automatic bit writes(int k);
    return pipe[k].v && pipe[k].rw && (pipe[k].a3 != 0);
  endfunction

  function automatic int eff(int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic bit stall_for(int src, int tuse);
    for (int k = 1; k <= 2; k++)
      if (writes(k) && pipe[k].a3 == src && eff(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  // Consumer in D or E: producers are always the M (2) and W (3) instructions.
  function automatic int fsel(int src);
    if (writes(2) && pipe[2].a3 == src && eff(2) == 0) return 1;
    if (writes(3) && pipe[3].a3 == src) return 2;
    return 0;
  endfunction

  function automatic void model_eval();
    e_stall = d_valid && (stall_for(int'(d_rs), int'(d_tuse_rs)) || stall_for(int'(d_rt), int'(d_tuse_rt)));
    e_fd_rs = fsel(int'(d_rs));
    e_fd_rt = fsel(int'(d_rt));
    e_fe_rs = fsel(pipe[1].rs);
    e_fe_rt = fsel(pipe[1].rt);
    e_fm_rt = (writes(3) && pipe[3].a3 == pipe[2].rt) ? 2 : 0;
  endfunction

  function automatic void model_clock();
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    if (e_stall) begin
      pipe[1] = bubble();
      m_cnt++;
    end else begin
      pipe[1] = '{v: d_valid, rw: d_regwrite, a3: int'(d_a3), rs: int'(d_rs),
                  rt: int'(d_rt), tnew: int'(d_tnew)};
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("stall", stall, e_stall);
    chk("fwd_d_rs", fwd_d_rs, e_fd_rs);
    chk("fwd_d_rt", fwd_d_rt, e_fd_rt);
    chk("fwd_e_rs", fwd_e_rs, e_fe_rs);
    chk("fwd_e_rt", fwd_e_rt, e_fe_rt);
    chk("fwd_m_rt", fwd_m_rt, e_fm_rt);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
    obs_stall = stall;
    obs_fd_rs = fwd_d_rs;
    obs_fd_rt = fwd_d_rt;
    obs_fe_rs = fwd_e_rs;
    obs_fm_rt = fwd_m_rt;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int tur, input int tut,
                       input int tn, input int a3, input bit rw);
    d_valid    = v;
    d_rs       = 5'(rs);
    d_rt       = 5'(rt);
    d_tuse_rs  = 4'(tur);
    d_tuse_rt  = 4'(tut);
    d_tnew     = 4'(tn);
    d_a3       = 5'(a3);
    d_regwrite = rw;
  endtask

  // Hold one instruction in D until it leaves; count the stalled cycles.
  task automatic issue(input string tag, input bit v, input int rs, input int rt, input int tur,
                       input int tut, input int tn, input int a3, input bit rw, input int exp_stalls);
    int n;
    n = 0;
    drive(v, rs, rt, tur, tut, tn, a3, rw);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (!obs_stall) break;
      n++;
    end
    chk({tag, "_stalls"}, n, exp_stalls);
  endtask

  task automatic nops(input int k);
    for (int i = 0; i < k; i++) issue("nop", 1'b0, 0, 0, 15, 15, 0, 0, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tuse_tab [4] = '{0, 1, 2, 15};

  initial begin
    model_reset();
    // Reset held with a hazard-shaped D instruction: every output must be 0.
    drive(1'b1, 3, 3, 0, 0, 3, 3, 1'b1);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_d_rs", fwd_d_rs, FWD_NONE);
    chk("rst_fwd_d_rt", fwd_d_rt, FWD_NONE);
    chk("rst_fwd_e_rs", fwd_e_rs, FWD_NONE);
    chk("rst_fwd_m_rt", fwd_m_rt, FWD_NONE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nops(1);

    // add $3 then beq $3,$4
    issue("add3", 1'b1, 1, 2, 1, 1, 2, 3, 1'b1, 0);
    issue("beq3", 1'b1, 3, 4, 0, 0, 0, 0, 1'b0, 1);
    chk("beq3_fwd_d_rs", obs_fd_rs, FWD_M);
    nops(3);

    // lw $5 then add $6,$5,$1
    issue("lw5", 1'b1, 2, 5, 1, 15, 3, 5, 1'b1, 0);
    issue("add6", 1'b1, 5, 1, 1, 1, 2, 6, 1'b1, 1);
    nops(1);
    chk("add6_fwd_e_rs", obs_fe_rs, FWD_W);
    nops(2);

    // lw $5 then beq $5,$0
    issue("lw5b", 1'b1, 2, 5, 1, 15, 3, 5, 1'b1, 0);
    issue("beq5", 1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 2);
    chk("beq5_fwd_d_rs", obs_fd_rs, FWD_W);
    nops(3);

    // lw $7 then sw $7,0($2)
    issue("lw7", 1'b1, 2, 7, 1, 15, 3, 7, 1'b1, 0);
    issue("sw7", 1'b1, 2, 7, 1, 2, 0, 0, 1'b0, 0);
    nops(2);
    chk("sw7_fwd_m_rt", obs_fm_rt, FWD_W);
    nops(2);

    // ori $0,$1,5 then add reading $0
    issue("ori0", 1'b1, 1, 0, 1, 15, 2, 0, 1'b1, 0);
    issue("add0", 1'b1, 0, 0, 1, 1, 2, 9, 1'b1, 0);
    chk("add0_fwd_d_rs", obs_fd_rs, FWD_NONE);
    chk("add0_fwd_d_rt", obs_fd_rt, FWD_NONE);
    nops(3);

    // Reset asserted in the middle of a lw-induced stall.
    issue("lw5r", 1'b1, 2, 5, 1, 15, 3, 5, 1'b1, 0);
    drive(1'b1, 5, 1, 1, 1, 2, 6, 1'b1);
    @(negedge clk);
    chk("rst_pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_fwd_d_rs", fwd_d_rs, FWD_NONE);
    chk("rst_mid_fwd_e_rs", fwd_e_rs, FWD_NONE);
`ifdef HAZARD_STATS_EN
    chk("rst_mid_stall_cnt", stall_cnt, 0);
`endif
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Same add still in D: the cleared scoreboard must not stall it.
    issue("add6_after_rst", 1'b1, 5, 1, 1, 1, 2, 6, 1'b1, 0);

    // Random traffic on a small register window to make hazards frequent.
    for (int i = 0; i < 1500; i++) begin
      if (!e_stall)
        drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              tuse_tab[$urandom_range(0, 3)], tuse_tab[$urandom_range(0, 3)],
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
